// File: rtl/gate_unit_arbiter_if.sv
// gate_unit_arbiter_if
//   Bundles the request side (N_REQ packed requesters) and the single
//   response port of the shared gate unit.
//
// Handshake rule (both directions): a transfer happens on a rising clk edge
// where valid and ready are both high. Once valid is raised, it and its
// payload stay stable until that transfer.
//
//   req_valid [N_REQ]        requester -> arbiter, one bit per requester
//   req_ready [N_REQ]        arbiter -> requester, one-hot or zero
//   req_a/req_b [N_REQ*WIDTH] operands, requester i at [i*WIDTH +: WIDTH]
//   req_op    [N_REQ*2]      opcode, requester i at [i*2 +: 2]
//   rsp_valid/rsp_ready      result handshake
//   rsp_data  [WIDTH]        result
//   rsp_id    [ID_W]         index of the requester owning rsp_data
//
// master: the requester/consumer side. slave: the arbiter.
interface gate_unit_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ*2-1:0]     req_op;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WIDTH-1:0]       rsp_data;
  logic [ID_W-1:0]        rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/gate_unit_arbiter.sv
// gate_unit_arbiter
//   Shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/NAND) between N_REQ
//   requesters with round-robin arbitration, one operation in flight.
//
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   bus       gate_unit_arbiter_if.slave (request ports + response port)
//   dbg_state current FSM state (0 IDLE, 1 ACCEPT, 2 RESP)
//
// Timing: a request seen in IDLE at cycle T is accepted (req_ready) in T+1
// and its result is presented from T+2. All outputs come from flops.
module gate_unit_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  gate_unit_arbiter_if.slave  bus,
  output logic [1:0]          dbg_state
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  ptr;
  logic [N_REQ-1:0] grant_r;
  logic [ID_W-1:0]  grant_idx;
  logic             rsp_valid_r;
  logic [WIDTH-1:0] rsp_data_r;
  logic [ID_W-1:0]  rsp_id_r;

  // Round-robin pick: first valid requester scanning ptr, ptr+1, ... mod N_REQ.
  logic             sel_found;
  logic [ID_W-1:0]  sel_idx;
  logic [ID_W-1:0]  cand;
  int               cand_i;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_i    = 0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_i = (int'(ptr) + k) % N_REQ;
      cand   = ID_W'(cand_i);
      if (!sel_found && bus.req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Operand mux and the gate unit itself, driven by the registered grant.
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       op_code;
  logic [WIDTH-1:0] op_res;

  always_comb begin
    op_a    = bus.req_a[int'(grant_idx)*WIDTH +: WIDTH];
    op_b    = bus.req_b[int'(grant_idx)*WIDTH +: WIDTH];
    op_code = bus.req_op[int'(grant_idx)*2 +: 2];
    case (op_code)
      2'b00:   op_res = op_a & op_b;
      2'b01:   op_res = op_a | op_b;
      2'b10:   op_res = op_a ^ op_b;
      default: op_res = ~(op_a & op_b);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      grant_r     <= '0;
      grant_idx   <= '0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      rsp_id_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            grant_r   <= ONE_HOT0 << sel_idx;
            grant_idx <= sel_idx;
            state     <= ACCEPT;
          end
        end
        ACCEPT: begin
          // grant_r is the accept strobe this cycle, so the operands are
          // captured on the same edge the requester sees its handshake.
          rsp_data_r  <= op_res;
          rsp_id_r    <= grant_idx;
          ptr         <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
          rsp_valid_r <= 1'b1;
          grant_r     <= '0;
          state       <= RESP;
        end
        RESP: begin
          // rsp_data/rsp_id are left holding the last result on purpose.
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = grant_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_id    = rsp_id_r;
  assign dbg_state     = state;

endmodule

// File: tb/tb_gate_unit_arbiter.sv
module tb_gate_unit_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;
  localparam int EW = IW + W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  gate_unit_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  gate_unit_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  pa [N];
  logic [W-1:0]  pb [N];
  logic [1:0]    pop [N];
  int            m_ptr;

  typedef struct {
    int         idx;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
  } vec_t;
  vec_t tbl [7];

  int order [5] = '{0, 1, 2, 3, 0};
  int ngr, last_c, g, waited;
  logic [N-1:0]  vh, drop_m;
  logic [EW-1:0] e;
  logic [W-1:0]  hold_d;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // ---------------- checker / driver tasks ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_op[i*2 +: 2] = op;
    pa[i] = a;
    pb[i] = b;
    pop[i] = op;
    bus.req_valid[i] = 1'b1;
  endtask

  // One isolated operation starting from IDLE with rsp_ready held high.
  task automatic do_op(input int idx, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] res);
    bus.rsp_ready = 1'b1;
    set_req(idx, a, b, op);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.req_ready == '0 && waited < 10);
    chk("op req_ready", 32'(bus.req_ready), 32'(1 << idx));
    chk("op accept latency", waited, 1);
    @(negedge clk);
    bus.req_valid[idx] = 1'b0;
    chk("op rsp_valid", 32'(bus.rsp_valid), 1);
    chk("op rsp_data", 32'(bus.rsp_data), 32'(res));
    chk("op rsp_id", 32'(bus.rsp_id), idx);
    @(negedge clk);
    chk("op rsp_valid drop", 32'(bus.rsp_valid), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    tbl[0] = '{2, 2'b01, 8'hF0, 8'h3C, 8'hFC};
    tbl[1] = '{0, 2'b00, 8'hAA, 8'h0F, 8'h0A};
    tbl[2] = '{0, 2'b01, 8'hAA, 8'h0F, 8'hAF};
    tbl[3] = '{0, 2'b10, 8'hAA, 8'h0F, 8'hA5};
    tbl[4] = '{0, 2'b11, 8'hAA, 8'h0F, 8'hF5};
    tbl[5] = '{3, 2'b00, 8'hC3, 8'h3C, 8'h00};
    tbl[6] = '{1, 2'b10, 8'h5A, 8'hFF, 8'hA5};

    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    bus.rsp_ready = 1'b0;

    // Reset with every requester asking: outputs must stay quiet.
    for (int i = 0; i < N; i++) set_req(i, 8'(8'h11 * (i + 1)), 8'h0F, 2'(i));
    bus.rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("reset req_ready", 32'(bus.req_ready), 0);
      chk("reset rsp_valid", 32'(bus.rsp_valid), 0);
      chk("reset rsp_data", 32'(bus.rsp_data), 0);
      chk("reset rsp_id", 32'(bus.rsp_id), 0);
    end
    rst_n = 1'b1;

    // Round-robin with all four requesters held valid.
    @(negedge clk);
    chk("first grant after reset", 32'(bus.req_ready), 32'b0001);
    ngr = 1;
    last_c = 0;
    for (int c = 1; c <= 20 && ngr < 5; c++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        chk("rr order", 32'(bus.req_ready), 32'(1 << order[ngr]));
        chk("rr spacing", c - last_c, 3);
        last_c = c;
        ngr++;
      end else if (bus.rsp_valid) begin
        chk("rr rsp", 32'({bus.rsp_id, bus.rsp_data}),
            32'({IW'(order[ngr-1]), ref_op(pop[order[ngr-1]], pa[order[ngr-1]], pb[order[ngr-1]])}));
      end
    end
    chk("rr grant count", ngr, 5);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rr drained", 32'(bus.rsp_valid), 0);

    // Opcode / single-op table.
    for (int t = 0; t < 7; t++)
      do_op(tbl[t].idx, tbl[t].op, tbl[t].a, tbl[t].b, tbl[t].res);

    // Backpressure: last grant was 1, so 3 wins, then 1 after release.
    bus.rsp_ready = 1'b0;
    set_req(1, 8'hF0, 8'hFF, 2'b00);
    set_req(3, 8'h12, 8'h34, 2'b10);
    @(negedge clk);
    chk("bp first grant", 32'(bus.req_ready), 32'b1000);
    @(negedge clk);
    bus.req_valid[3] = 1'b0;
    hold_d = 8'h26;
    for (int c = 0; c < 5; c++) begin
      chk("bp rsp_valid hold", 32'(bus.rsp_valid), 1);
      chk("bp rsp_data hold", 32'(bus.rsp_data), 32'(hold_d));
      chk("bp rsp_id hold", 32'(bus.rsp_id), 3);
      chk("bp req_ready quiet", 32'(bus.req_ready), 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp rsp_valid release", 32'(bus.rsp_valid), 0);
    chk("bp rsp_data kept", 32'(bus.rsp_data), 32'(hold_d));
    @(negedge clk);
    chk("bp next grant", 32'(bus.req_ready), 32'b0010);
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    chk("bp second rsp", 32'({bus.rsp_id, bus.rsp_data}), 32'({2'd1, 8'hF0}));
    @(negedge clk);

    // Reset during RESP of a req-1 operation.
    bus.rsp_ready = 1'b0;
    set_req(1, 8'h0F, 8'hF0, 2'b01);
    @(negedge clk);
    chk("mid op grant", 32'(bus.req_ready), 32'b0010);
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    chk("mid op rsp_valid", 32'(bus.rsp_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid reset rsp_valid async", 32'(bus.rsp_valid), 0);
    chk("mid reset rsp_data", 32'(bus.rsp_data), 0);
    set_req(1, 8'h33, 8'h0F, 2'b00);
    set_req(3, 8'h44, 8'h0F, 2'b00);
    @(negedge clk);
    chk("mid reset req_ready", 32'(bus.req_ready), 0);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("post reset grant", 32'(bus.req_ready), 32'b0010);
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    chk("post reset rsp", 32'({bus.rsp_id, bus.rsp_data}), 32'({2'd1, 8'h03}));
    @(negedge clk);
    @(negedge clk);
    chk("post reset second grant", 32'(bus.req_ready), 32'b1000);
    @(negedge clk);
    bus.req_valid[3] = 1'b0;
    chk("post reset second rsp", 32'({bus.rsp_id, bus.rsp_data}), 32'({2'd3, 8'h04}));
    @(negedge clk);

    // Randomized traffic against the transaction-level model.
    rst_n = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    drop_m = '0;
    for (int cyc = 0; cyc < 1600; cyc++) begin
      @(negedge clk);
      vh = bus.req_valid;
      bus.req_valid = bus.req_valid & ~drop_m;
      drop_m = '0;
      if (bus.req_ready != '0) begin
        g = rr_pick(vh, m_ptr);
        chk("rand grant", 32'(bus.req_ready), (g < 0) ? 32'd0 : 32'(1 << g));
        if (g >= 0) begin
          exp_q.push_back({IW'(g), ref_op(pop[g], pa[g], pb[g])});
          m_ptr = (g + 1) % N;
        end
        drop_m = bus.req_ready;
      end
      if (cyc < 1500) begin
        for (int i = 0; i < N; i++)
          if (!bus.req_valid[i] && $urandom_range(0, 2) == 0)
            set_req(i, W'($urandom), W'($urandom), 2'($urandom_range(0, 3)));
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rand rsp: got id %0d data 0x%0h, want no response", bus.rsp_id, bus.rsp_data);
        end else begin
          e = exp_q.pop_front();
          chk("rand rsp", 32'({bus.rsp_id, bus.rsp_data}), 32'(e));
        end
      end
    end
    chk("rand queue drained", exp_q.size(), 0);
    chk("rand requesters idle", 32'(bus.req_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gate_unit_arbiter.md
Name: gate_unit_arbiter

Overview:
- Shares one WIDTH-bit two-input logic unit (AND/OR/XOR/NAND) between N_REQ requesters.
- Round-robin arbitration; valid/ready handshake on each request port and on the single response port.
- Sits between the lab's stimulus sources and the shared gate datapath. Serves one operation at a time.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width in bits.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester accept strobe, one-hot or zero.
- req_a  input  N_REQ*WIDTH  operand a; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  N_REQ*WIDTH  operand b; same packing as req_a.
- req_op  input  N_REQ*2  opcode; requester i occupies bits [i*2 +: 2].
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  WIDTH  result.
- rsp_id  output  clog2(N_REQ)  index of the requester that owns rsp_data.

Behaviour:
- Opcode: 00 a&b, 01 a|b, 10 a^b, 11 ~(a&b). Bitwise; result is WIDTH bits; no carry.
- Reset (rst_n low, takes effect immediately): state=IDLE, ptr=0, grant_r=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0. All outputs are registered, so none depends on inputs during reset.
- FSM states are IDLE, ACCEPT and RESP.
- IDLE:
  - If any req_valid is high, select the grant with round-robin. Search order is ptr, ptr+1, … mod N_REQ; the first valid requester wins.
  - Register the grant one-hot into grant_r and go to ACCEPT.
  - If no req_valid is high, stay in IDLE.
- ACCEPT (exactly 1 cycle):
  - req_ready = grant_r.
  - At the clock edge: rsp_data <= op(a,b) of the granted requester; rsp_id <= grant index; ptr <= (grant index+1) mod N_REQ; rsp_valid <= 1; grant_r <= 0. Go to RESP.
- RESP:
  - Hold rsp_valid=1 with rsp_data and rsp_id stable.
  - On rsp_valid & rsp_ready: rsp_valid <= 0 and go to IDLE.
  - rsp_data and rsp_id keep their last value after the handshake.
- Latency:
  - req_valid seen in IDLE at cycle T; req_ready is high in T+1; rsp_valid is high from T+2.
  - If rsp_ready is held high, the minimum period is 3 cycles per operation.
- Requester protocol:
  - Once raised, req_valid and its payload stay stable until req_ready is seen.
  - Dropping valid early is a protocol violation; the result is undefined, and the bench must not do it.
- rsp_ready high in the first RESP cycle completes the handshake in that cycle.
- rsp_ready is ignored in IDLE and ACCEPT.
- New requests arriving in ACCEPT or RESP wait; they are evaluated in the next IDLE.
- With a single active requester, that requester is granted every round regardless of ptr.
- ptr wrap-around: a grant to N_REQ-1 sets ptr=0.
- Reset mid-operation (any state): the in-flight operation is dropped, no response is produced, and ptr returns to 0.

Test Plan:
- Reset: assert rst_n=0 with all req_valid=1 -> req_ready=0, rsp_valid=0, rsp_data=0x00, rsp_id=0 throughout reset; first grant after release goes to requester 0.
- Single op: req 2 sends a=0xF0, b=0x3C, op=01 at T, rsp_ready=1 -> req_ready=4'b0100 at T+1; at T+2 rsp_valid=1, rsp_data=0xFC, rsp_id=2.
- All opcodes on req 0 with a=0xAA, b=0x0F -> AND=0x0A, OR=0xAF, XOR=0xA5, NAND=0xF5.
- Round-robin: all four req_valid held high with rsp_ready=1 -> grant order 0,1,2,3,0; ptr wraps after 3; responses spaced 3 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles in RESP while req 1 and req 3 are valid -> rsp_valid, rsp_data and rsp_id stay stable and req_ready stays 0; after rsp_ready=1 the next grant goes to the requester after the last grant.
- Reset mid-op: drop rst_n during RESP of a req-1 op -> rsp_valid goes to 0 immediately; after release with req 1 and req 3 valid, req 1 is granted first (ptr=0).
